// File: rtl/ula_pkg.sv
// Shared opcode, format, state and flag definitions for the pipelined ULA.
package ula_pkg;

  localparam logic [1:0] FMT_LCL = 2'b00;
  localparam logic [1:0] FMT_LCH = 2'b01;
  localparam logic [1:0] FMT_ALU = 2'b10;
  localparam logic [1:0] FMT_LDI = 2'b11;

  localparam logic [1:0] GRP_ARITH = 2'b00;
  localparam logic [1:0] GRP_LOGIC = 2'b01;
  localparam logic [1:0] GRP_SHIFT = 2'b10;
  localparam logic [1:0] GRP_ZERO  = 2'b11;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_SUBD  = 5'b00011;
  localparam logic [4:0] OP_INC   = 5'b00100;
  localparam logic [4:0] OP_DEC   = 5'b00101;
  localparam logic [4:0] OP_NEG   = 5'b00110;
  localparam logic [4:0] OP_PASSA = 5'b00111;
  localparam logic [4:0] OP_AND   = 5'b01000;
  localparam logic [4:0] OP_OR    = 5'b01001;
  localparam logic [4:0] OP_XOR   = 5'b01010;
  localparam logic [4:0] OP_NOT   = 5'b01011;
  localparam logic [4:0] OP_PASSB = 5'b01100;
  localparam logic [4:0] OP_SHL   = 5'b10000;
  localparam logic [4:0] OP_SHR   = 5'b10001;
  localparam logic [4:0] OP_SAR   = 5'b10010;

  typedef enum logic {IDLE, SHIFT} state_t;

  typedef struct packed {
    logic o;
    logic c;
    logic s;
    logic z;
  } flags_t;

endpackage

// File: rtl/ula_pipe_comb.sv
// Single-cycle result and flags for the arithmetic, logic and constant groups.
// A shift-group opcode yields A unchanged, which is the correct result for N==0.
module ula_pipe_comb
  import ula_pkg::*;
#(
  parameter int bits = 16
) (
  input  logic [bits-1:0] i_a,
  input  logic [bits-1:0] i_b,
  input  logic [7:0]      i_op,
  output logic [bits-1:0] o_resu,
  output flags_t          o_flags
);

  localparam int H = bits / 2;

  logic signed [bits-1:0] w_x;
  logic signed [bits-1:0] w_y;
  logic                   w_cin;
  logic                   w_arith;
  logic        [bits:0]   w_sum;
  logic        [bits-1:0] w_res;
  logic                   w_o;
  logic                   w_c;

  always_comb begin
    w_x     = '0;
    w_y     = '0;
    w_cin   = 1'b0;
    w_arith = 1'b0;
    w_sum   = '0;
    w_res   = '0;
    w_o     = 1'b0;
    w_c     = 1'b0;
    case (i_op[7:6])
      FMT_LCL: w_res = i_op[5] ? {{(bits-H){1'b0}}, i_b[H-1:0]} : {i_a[bits-1:H], i_b[H-1:0]};
      FMT_LCH: w_res = i_op[5] ? {i_b[H-1:0], {H{1'b0}}} : {i_b[H-1:0], i_a[H-1:0]};
      FMT_LDI: w_res = i_b;
      FMT_ALU: begin
        case (i_op[4:3])
          GRP_ARITH: begin
            // every arithmetic op is one adder pass: x + y + cin
            w_arith = 1'b1;
            case (i_op[4:0])
              OP_ADD:  begin w_x = i_a; w_y = i_b; end
              OP_ADDI: begin w_x = i_a; w_y = i_b; w_cin = 1'b1; end
              OP_SUB:  begin w_x = i_a; w_y = ~i_b; w_cin = 1'b1; end
              OP_SUBD: begin w_x = i_a; w_y = ~i_b; end
              OP_INC:  begin w_x = i_a; w_cin = 1'b1; end
              OP_DEC:  begin w_x = i_a; w_y = '1; end
              OP_NEG:  begin w_y = ~i_a; w_cin = 1'b1; end
              OP_PASSA: w_x = i_a;
              default:  w_x = i_a;
            endcase
          end
          GRP_LOGIC: begin
            case (i_op[4:0])
              OP_AND:   w_res = i_a & i_b;
              OP_OR:    w_res = i_a | i_b;
              OP_XOR:   w_res = i_a ^ i_b;
              OP_NOT:   w_res = ~i_a;
              OP_PASSB: w_res = i_b;
              default:  w_res = '0;
            endcase
          end
          GRP_SHIFT: w_res = i_a;
          GRP_ZERO:  w_res = '0;
          default:   w_res = '0;
        endcase
      end
      default: w_res = '0;
    endcase

    if (w_arith) begin
      w_sum = {1'b0, w_x} + {1'b0, w_y} + {{bits{1'b0}}, w_cin};
      w_res = w_sum[bits-1:0];
      w_c   = w_sum[bits];
      w_o   = (w_x[bits-1] == w_y[bits-1]) && (w_res[bits-1] != w_x[bits-1]);
    end
  end

  assign o_resu  = w_res;
  assign o_flags = {w_o, w_c, w_res[bits-1], ~|w_res};

endmodule

// File: rtl/ula_pipe.sv
// Registered ULA with valid/ready handshake and an iterative shifter that
// advances SH_STEP bit positions per SHIFT cycle.
module ula_pipe
  import ula_pkg::*;
#(
  parameter int bits    = 16,
  parameter int SH_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [bits-1:0] A,
  input  logic [bits-1:0] B,
  input  logic [7:0]      OP,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [bits-1:0] RESU,
  output logic            O,
  output logic            C,
  output logic            S,
  output logic            Z,
  output logic            busy
);

  localparam int            NW   = $clog2(bits);
  localparam int            CW   = NW + 1;
  localparam logic [CW-1:0] STEP = CW'(SH_STEP);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [bits-1:0] r_work_p0;
  logic [NW-1:0]   r_rem_p0;
  logic            r_right_p0;
  logic            r_arith_p0;
  logic            r_vld_p1;
  logic [bits-1:0] r_resu_p1;
  flags_t          r_flags_p1;

  logic [bits-1:0] w_comb_res;
  flags_t          w_comb_flags;
  logic [NW-1:0]   w_n;
  logic            w_is_shift;
  logic            w_right;
  logic            w_arith;
  logic            w_accept;
  logic            w_start_shift;
  logic            w_last;
  logic [CW-1:0]   w_rem_ext;
  logic [CW-1:0]   w_step;
  logic [bits:0]   w_ext_l;
  logic [bits:0]   w_ext_r;
  logic [bits-1:0] w_shifted;
  logic            w_cout;

  assign w_n           = B[NW-1:0];
  assign w_is_shift    = (OP[7:6] == FMT_ALU) && (OP[4:3] == GRP_SHIFT);
  assign in_ready      = rst_n && (r_state == IDLE) && (!r_vld_p1 || out_ready);
  assign w_accept      = in_valid && in_ready;
  assign w_start_shift = w_accept && w_is_shift && (w_n != '0);

  always_comb begin
    w_right = 1'b0;
    w_arith = 1'b0;
    case (OP[4:0])
      OP_SHR:  w_right = 1'b1;
      OP_SAR:  begin w_right = 1'b1; w_arith = 1'b1; end
      OP_SHL:  w_right = 1'b0;
      default: w_right = 1'b0;
    endcase
  end

  ula_pipe_comb #(.bits(bits)) u_comb (
    .i_a     (A),
    .i_b     (B),
    .i_op    (OP),
    .o_resu  (w_comb_res),
    .o_flags (w_comb_flags)
  );

  assign w_rem_ext = {1'b0, r_rem_p0};
  assign w_step    = (w_rem_ext < STEP) ? w_rem_ext : STEP;
  assign w_last    = (r_state == SHIFT) && (w_rem_ext <= STEP);

  // One guard bit on each side catches the last bit shifted out as carry.
  always_comb begin
    w_ext_l = {1'b0, r_work_p0} << w_step;
    if (r_arith_p0) w_ext_r = $unsigned($signed({r_work_p0, 1'b0}) >>> w_step);
    else            w_ext_r = {r_work_p0, 1'b0} >> w_step;
    if (r_right_p0) begin
      w_shifted = w_ext_r[bits:1];
      w_cout    = w_ext_r[0];
    end else begin
      w_shifted = w_ext_l[bits-1:0];
      w_cout    = w_ext_l[bits];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_shift) w_state_nxt = SHIFT;
      SHIFT:   if (w_last)        w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // p0: shifter working register, loaded at accept
  always_ff @(posedge clk) begin
    if (w_start_shift) begin
      r_work_p0  <= A;
      r_rem_p0   <= w_n;
      r_right_p0 <= w_right;
      r_arith_p0 <= w_arith;
    end else if (r_state == SHIFT) begin
      r_work_p0 <= w_shifted;
      r_rem_p0  <= r_rem_p0 - w_step[NW-1:0];
    end
  end

  // p1: output register; holds while out_valid && !out_ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1   <= 1'b0;
      r_resu_p1  <= '0;
      r_flags_p1 <= '0;
    end else if (w_last) begin
      r_vld_p1   <= 1'b1;
      r_resu_p1  <= w_shifted;
      r_flags_p1 <= {1'b0, w_cout, w_shifted[bits-1], ~|w_shifted};
    end else if (w_accept && !w_start_shift) begin
      r_vld_p1   <= 1'b1;
      r_resu_p1  <= w_comb_res;
      r_flags_p1 <= w_comb_flags;
    end else if (r_vld_p1 && out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign out_valid = r_vld_p1;
  assign RESU      = r_resu_p1;
  assign O         = r_flags_p1.o;
  assign C         = r_flags_p1.c;
  assign S         = r_flags_p1.s;
  assign Z         = r_flags_p1.z;
  assign busy      = (r_state == SHIFT);

endmodule
